ovl_event_sequence_gen: RTL and testbench
=========================================

// Module: ovl_event_sequence_gen
// PURPOSE
//  Stimulus generator for ovl_cycle_sequence checkers in ivl_uvm OVL tests.
//  On start it drives a walking-one event_sequence, MSB first, toward the LSB,
//  holding each step for a programmable number of clocks.
//  Its output connects directly to a checker's event_sequence input, so pass/fail
//  tests need no hand-written task sequences.
// PARAMETERS
//  NUM_CKS   4  width of event_sequence; must match the checker's num_cks (>=2)
//  CNT_W     8  width of hold_cycles and of the internal hold counter
// PORTS
//  clock          in   1          sampling clock, rising edge
//  reset          in   1          asynchronous, active-low
//  enable         in   1          1=run; 0=freeze state, counters and outputs
//  start          in   1          request one sequence; sampled only in IDLE
//  hold_cycles    in   CNT_W      clocks per step; latched at start; 0 treated as 1
//  loop_en        in   1          1=restart the sequence after DONE, without a new start
//  err_inj        in   1          request fault injection on next run (see CONFIGURATION)
//  err_idx        in   $clog2(NUM_CKS)  step to corrupt; latched at start
//  event_sequence out  NUM_CKS    one-hot step pattern, or 0 when not stepping
//  step_idx       out  $clog2(NUM_CKS)  current step; 0 = MSB step
//  busy           out  1          high in STEP and DONE
//  done           out  1          one-cycle pulse at the end of each sequence
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; event_sequence=0; step_idx=0; busy=0;
//   done=0; hold counter=0; latched hold and err values=0.
//  FSM: IDLE -> STEP -> DONE -> IDLE, or DONE -> STEP when loop_en==1.
//  IDLE: outputs 0. At a posedge with enable&start: latch hold_cycles (0->1),
//   err_idx and err_inj. Next cycle: state=STEP, step_idx=0,
//   event_sequence=1<<(NUM_CKS-1). Latency is 1 clock from start to the first event.
//  STEP: event_sequence=1<<(NUM_CKS-1-step_idx). Hold counter counts 1..H.
//   At count H: if step_idx<NUM_CKS-1, increment step_idx, reset the counter and
//   shift the pattern right by 1. Otherwise go to DONE.
//   Each step is visible for exactly H clocks. Total run = NUM_CKS*H clocks.
//  DONE: 1 cycle. event_sequence=0, done=1, busy=1. Then:
//   loop_en==1 -> STEP with step_idx=0, reusing the latched H and err values,
//    so MSB is driven again 1 clock after done.
//   loop_en==0 -> IDLE.
//  start while busy: ignored; no queuing.
//  start and loop_en together in DONE: loop_en wins; start is ignored.
//  enable==0: all registers hold, outputs stay at the current values, done is
//   not re-pulsed, and the hold count does not advance. Resume continues
//   mid-step with the remaining count.
//  Counter width: H up to 2^CNT_W-1. The counter compares for equality with no
//   overflow, and wraps only through its reset to 1.
//  Reset asserted mid-sequence: outputs go to 0 immediately (asynchronously).
//   No done pulse. After release the block sits in IDLE until a new start.
//  step_idx is valid only while in STEP; it is 0 in IDLE and DONE.
// CONFIGURATION
//  Macro OVL_SEQ_GEN_ERR_INJ_EN:
//   Defined: if the latched err_inj==1, the step equal to the latched err_idx
//    drives event_sequence=0 for its H clocks. This creates a broken chain for
//    fail tests. step_idx and timing are unchanged.
//   Undefined: err_inj and err_idx are ignored, no injection logic is built,
//    and outputs are identical to err_inj==0.
// TESTING
//  T1 reset=0 3 clks, NUM_CKS=4, H=2, start pulse -> event_sequence 1000,0100,
//     0010,0001 for 2 clks each; done at clk 9 after start; checker silent.
//  T2 hold_cycles=0 -> H=1; the pattern changes every clock; done 5 clks after start.
//  T3 enable=0 for 3 clks during step 0100 (after 1 clk held) -> 0100 stays
//     for 1+3+1 clks total; the rest of the timing is unchanged.
//  T4 loop_en=1, H=1 -> 1000,0100,0010,0001,0000(done),1000,... repeating
//     every 5 clks; start pulses while busy have no effect.
//  T5 reset=0 asserted while driving 0010 -> event_sequence=0 within the same
//     cycle; no done; after release stays 0 until a new start.
//  T6 OVL_SEQ_GEN_ERR_INJ_EN defined, err_inj=1, err_idx=2, H=1 ->
//     1000,0100,0000,0001; checker fires. Without the macro: normal pattern, no fire.

Source files
------------

// File: rtl/ovl_event_sequence_gen.sv
// ovl_event_sequence_gen: walking-one event_sequence stimulus for ovl_cycle_sequence checkers.
// Build option OVL_SEQ_GEN_ERR_INJ_EN adds a blanked-step fault injector for fail tests.
module ovl_event_sequence_gen #(
  parameter int NUM_CKS = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic [CNT_W-1:0]           hold_cycles,
  input  logic                       loop_en,
  input  logic                       err_inj,
  input  logic [$clog2(NUM_CKS)-1:0] err_idx,
  output logic [NUM_CKS-1:0]         event_sequence,
  output logic [$clog2(NUM_CKS)-1:0] step_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(NUM_CKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CKS - 1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_step_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic             w_corrupt;
  logic             w_take_start;

  // Step 0 drives the MSB; each later step moves one bit toward the LSB.
  function automatic logic [NUM_CKS-1:0] f_step_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CKS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CKS; i++) begin
      v[i] = (i == (NUM_CKS - 1 - int'(idx)));
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] f_hold_min1(input logic [CNT_W-1:0] h);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  assign w_take_start = enable && start && (r_state == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_step_idx <= '0;
      r_cnt      <= '0;
      r_hold     <= '0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_STEP;
            r_step_idx <= '0;
            r_cnt      <= CNT_W'(1);
            r_hold     <= f_hold_min1(hold_cycles);
          end
        end
        S_STEP: begin
          // Equality compare only: r_cnt never passes r_hold, so no overflow path exists.
          if (r_cnt == r_hold) begin
            r_cnt <= CNT_W'(1);
            if (r_step_idx == LAST_IDX) begin
              r_state    <= S_DONE;
              r_step_idx <= '0;
            end else begin
              r_step_idx <= r_step_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_step_idx <= '0;
          // loop_en has priority; start is never sampled outside IDLE.
          if (loop_en) begin
            r_state <= S_STEP;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_step_idx <= '0;
          r_cnt      <= '0;
        end
      endcase
    end
  end

`ifdef OVL_SEQ_GEN_ERR_INJ_EN
  logic             r_err_inj;
  logic [IDX_W-1:0] r_err_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_inj <= 1'b0;
      r_err_idx <= '0;
    end else if (w_take_start) begin
      r_err_inj <= err_inj;
      r_err_idx <= err_idx;
    end
  end

  assign w_corrupt = r_err_inj && (r_err_idx == r_step_idx);
`else
  logic w_unused_err;

  assign w_unused_err = ^{err_inj, err_idx, w_take_start};
  assign w_corrupt    = 1'b0;
`endif

  // Outputs decode registered state only, so an async reset clears them at once.
  assign event_sequence = ((r_state == S_STEP) && !w_corrupt) ? f_step_onehot(r_step_idx) : '0;
  assign step_idx       = r_step_idx;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);

endmodule

// File: tb/tb_ovl_event_sequence_gen.sv
// Scoreboard bench for ovl_event_sequence_gen (NUM_CKS=4, CNT_W=8).
// Honours OVL_SEQ_GEN_ERR_INJ_EN when choosing the expected fault-injection pattern.
module tb_ovl_event_sequence_gen;

  localparam int NUM_CKS = 4;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [3:0] seq;
    logic [1:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] hold_cycles = '0;
  logic             loop_en = 1'b0;
  logic             err_inj = 1'b0;
  logic [1:0]       err_idx = '0;
  logic [3:0]       event_sequence;
  logic [1:0]       step_idx;
  logic             busy;
  logic             done;

  obs_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef OVL_SEQ_GEN_ERR_INJ_EN
  localparam bit INJ_BUILT = 1'b1;
`else
  localparam bit INJ_BUILT = 1'b0;
`endif

  ovl_event_sequence_gen #(.NUM_CKS(NUM_CKS), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .hold_cycles    (hold_cycles),
    .loop_en        (loop_en),
    .err_inj        (err_inj),
    .err_idx        (err_idx),
    .event_sequence (event_sequence),
    .step_idx       (step_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  function automatic obs_t sample();
    obs_t o;
    o.seq  = event_sequence;
    o.idx  = step_idx;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("seq=%b idx=%0d busy=%b done=%b", o.seq, o.idx, o.busy, o.done);
  endfunction

  task automatic push_obs(logic [3:0] s, logic [1:0] i, logic b, logic d);
    obs_t o;
    o.seq = s; o.idx = i; o.busy = b; o.done = d;
    exp_q.push_back(o);
  endtask

  // One full sequence: NUM_CKS steps of h clocks each, then the done cycle.
  task automatic push_run(int h, bit inj, int ei);
    for (int s = 0; s < NUM_CKS; s++) begin
      for (int k = 0; k < h; k++) begin
        if (inj && s == ei) push_obs(4'b0000, 2'(s), 1'b1, 1'b0);
        else                push_obs(4'b1000 >> s, 2'(s), 1'b1, 1'b0);
      end
    end
    push_obs(4'b0000, 2'd0, 1'b1, 1'b1);
  endtask

  task automatic push_idle(int n);
    repeat (n) push_obs(4'b0000, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t g;
    obs_t e;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      g = sample();
      n_assert++;
      if (g !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %s, want all zero", i, fmt(g));
      end
    end
    reset = 1'b1;
    push_idle(2);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_basic();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd2;
    start = 1'b1;
    push_run(2, 1'b0, 0);
    push_idle(2);
    for (int i = 1; i <= 11; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL basic_h2 cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = 1'b0;
    end
  endtask

  task automatic test_hold_zero();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd0;
    start = 1'b1;
    push_run(1, 1'b0, 0);
    push_idle(1);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hold_zero cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = 1'b0;
    end
  endtask

  task automatic test_enable();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd2;
    start = 1'b1;
    repeat (2) push_obs(4'b1000, 2'd0, 1'b1, 1'b0);
    repeat (5) push_obs(4'b0100, 2'd1, 1'b1, 1'b0);
    repeat (2) push_obs(4'b0010, 2'd2, 1'b1, 1'b0);
    repeat (2) push_obs(4'b0001, 2'd3, 1'b1, 1'b0);
    push_obs(4'b0000, 2'd0, 1'b1, 1'b1);
    push_idle(1);
    for (int i = 1; i <= 13; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL enable_freeze cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start  = 1'b0;
      enable = !(i >= 3 && i <= 5);
    end
    enable = 1'b1;
  endtask

  task automatic test_loop();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd1;
    loop_en = 1'b1;
    start = 1'b1;
    push_run(1, 1'b0, 0);
    push_run(1, 1'b0, 0);
    push_run(1, 1'b0, 0);
    push_idle(2);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL loop cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = (i % 3 == 0) && (i < 12);
      if (i == 11) loop_en = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd1;
    start = 1'b1;
    push_run(1, 1'b0, 0);
    push_idle(1);
    push_run(1, 1'b0, 0);
    push_idle(1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      if (i == 7) start = 1'b0;
    end
  endtask

  task automatic test_max_hold();
    obs_t g;
    obs_t e;
    int   n;
    hold_cycles = 8'd255;
    start = 1'b1;
    push_run(255, 1'b0, 0);
    push_idle(1);
    n = exp_q.size();
    hold_cycles = 8'd255;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL max_hold cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = 1'b0;
      hold_cycles = 8'd3;
    end
  endtask

  task automatic test_reset_mid();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd2;
    start = 1'b1;
    repeat (2) push_obs(4'b1000, 2'd0, 1'b1, 1'b0);
    repeat (2) push_obs(4'b0100, 2'd1, 1'b1, 1'b0);
    push_obs(4'b0010, 2'd2, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid_run cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    g = sample();
    n_assert++;
    if (g !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %s, want all zero", fmt(g));
    end
    @(posedge clock); #1;
    reset = 1'b1;
    push_idle(3);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid_after cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_err_inj();
    obs_t g;
    obs_t e;
    hold_cycles = 8'd1;
    err_inj = 1'b1;
    err_idx = 2'd2;
    start = 1'b1;
    push_run(1, INJ_BUILT, 2);
    push_idle(1);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock); #1;
      g = sample(); e = exp_q.pop_front();
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL err_inj cycle %0d: got %s, want %s", i, fmt(g), fmt(e));
      end
      start = 1'b0;
      err_inj = 1'b0;
      err_idx = 2'd0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_zero();
    test_enable();
    test_loop();
    test_back_to_back();
    test_max_hold();
    test_reset_mid();
    test_err_inj();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
